// File: rtl/serial_word_receiver.sv
// serial_word_receiver: start/data/stop serial frame capture with valid/ack handoff,
// framing-error pulse and sticky overrun flag.
module serial_word_receiver #(
    parameter int WIDTH = 4,
    parameter bit DIR   = 1'b1
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             W,
    input  logic             Ack,
    output logic [WIDTH-1:0] Q,
    output logic             Valid,
    output logic             FrameErr,
    output logic             Overrun,
    output logic             Busy
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP} state_t;
    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sh, r_q, w_sh_next;
    logic             r_valid, r_fe, r_ovr;
    logic             w_last, w_stop, w_commit, w_drop;
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end
    always_comb begin
        w_last = (r_cnt == CW'(WIDTH - 1));
        w_next = (r_state == S_IDLE) ? (W ? S_IDLE : S_DATA) :
                 (r_state == S_DATA) ? (w_last ? S_STOP : S_DATA) : S_IDLE;
    end
    always_comb begin
        w_stop    = (r_state == S_STOP);
        w_commit  = w_stop && W && (!r_valid || Ack);
        w_drop    = w_stop && W && r_valid && !Ack;
        w_sh_next = DIR ? {r_sh[WIDTH-2:0], W} : {W, r_sh[WIDTH-1:1]};
        Busy      = (r_state != S_IDLE);
    end
    // A commit at the same edge as Ack keeps Valid high with the new word.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt   <= '0;
            r_sh    <= '0;
            r_q     <= '0;
            r_valid <= 1'b0;
            r_fe    <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (r_state == S_IDLE && !W) r_cnt <= '0;
            else if (r_state == S_DATA) begin
                r_cnt <= r_cnt + 1'b1;
                r_sh  <= w_sh_next;
            end
            if (w_commit) r_q <= r_sh;
            r_valid <= w_commit || (r_valid && !Ack);
            r_fe    <= w_stop && !W;
            r_ovr   <= (r_valid && Ack) ? 1'b0 : (r_ovr || w_drop);
        end
    end
    assign Q        = r_q;
    assign Valid    = r_valid;
    assign FrameErr = r_fe;
    assign Overrun  = r_ovr;
endmodule

// File: tb/tb_serial_word_receiver.sv
// tb_serial_word_receiver: directed and random frames into a left-shift and a
// right-shift receiver, checked against a frame-level model.
module tb_serial_word_receiver;
    logic       Clock = 1'b0;
    logic       Reset_n, W, Ack;
    logic [3:0] q1, q0;
    logic       v1, v0, fe1, fe0, ov1, ov0, b1, b0;
    int         n_assert = 0;
    int         n_fail = 0;
    logic [3:0] e_q1, e_q0;
    logic       e_v, e_ov, e_fe, e_busy;

    serial_word_receiver #(.WIDTH(4), .DIR(1'b1)) u_left (
        .Clock(Clock), .Reset_n(Reset_n), .W(W), .Ack(Ack),
        .Q(q1), .Valid(v1), .FrameErr(fe1), .Overrun(ov1), .Busy(b1));
    serial_word_receiver #(.WIDTH(4), .DIR(1'b0)) u_right (
        .Clock(Clock), .Reset_n(Reset_n), .W(W), .Ack(Ack),
        .Q(q0), .Valid(v0), .FrameErr(fe0), .Overrun(ov0), .Busy(b0));

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " q_left"}, 32'(q1), 32'(e_q1));
        chk({tag, " q_right"}, 32'(q0), 32'(e_q0));
        chk({tag, " valid"}, 32'({v1, v0}), 32'({e_v, e_v}));
        chk({tag, " overrun"}, 32'({ov1, ov0}), 32'({e_ov, e_ov}));
        chk({tag, " frameerr"}, 32'({fe1, fe0}), 32'({e_fe, e_fe}));
        chk({tag, " busy"}, 32'({b1, b0}), 32'({e_busy, e_busy}));
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic model_reset();
        e_q1 = '0; e_q0 = '0; e_v = 0; e_ov = 0; e_fe = 0; e_busy = 0;
    endtask

    // Drives start, four data bits (d[3] first), stop; W returns high afterwards.
    task automatic send_frame(input string tag, input logic [3:0] d, input logic stop, input logic ack_at_stop);
        logic [3:0] arrived;
        logic       commit;
        W = 1'b0; Ack = 1'b0;
        tick();
        e_fe = 0; e_busy = 1;
        chk({tag, " busy_start"}, 32'({b1, b0}), 32'b11);
        for (int i = 0; i < 4; i++) begin
            W = d[3-i];
            arrived[i] = d[3-i];
            tick();
        end
        chk({tag, " busy_data"}, 32'({b1, b0}), 32'b11);
        W = stop; Ack = ack_at_stop;
        tick();
        commit = stop && (!e_v || ack_at_stop);
        e_fe   = !stop;
        e_busy = 0;
        if (ack_at_stop && e_v) e_ov = 0;
        if (stop && e_v && !ack_at_stop) e_ov = 1;
        if (commit) begin
            e_v = 1;
            for (int i = 0; i < 4; i++) begin
                e_q1[3-i] = arrived[i];
                e_q0[i]   = arrived[i];
            end
        end else if (ack_at_stop) e_v = 0;
        W = 1'b1; Ack = 1'b0;
        check_all({tag, " stop"});
    endtask

    task automatic idle(input string tag, input logic ack);
        W = 1'b1; Ack = ack;
        tick();
        if (ack && e_v) begin e_v = 0; e_ov = 0; end
        e_fe = 0;
        Ack = 1'b0;
        check_all(tag);
    endtask

    initial begin
        Reset_n = 1'b0; W = 1'b1; Ack = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        tick();
        Reset_n = 1'b1;
        tick();
        check_all("after_reset");

        send_frame("f1101", 4'b1101, 1'b1, 1'b0);
        idle("ack1101", 1'b1);
        send_frame("badstop", 4'b1001, 1'b0, 1'b0);
        idle("fe_clear", 1'b0);
        idle("stay_idle", 1'b0);

        send_frame("ovr_a", 4'b1101, 1'b1, 1'b0);
        send_frame("ovr_b", 4'b0110, 1'b1, 1'b0);
        idle("ovr_ack", 1'b1);

        send_frame("sim_a", 4'b1101, 1'b1, 1'b0);
        send_frame("sim_b", 4'b0110, 1'b1, 1'b1);
        idle("sim_ack", 1'b1);
        idle("ack_ignored", 1'b1);

        send_frame("pre_rst", 4'b1111, 1'b1, 1'b0);
        W = 1'b0; tick();
        W = 1'b1; tick();
        W = 1'b1; tick();
        Reset_n = 1'b0;
        #1;
        model_reset();
        check_all("mid_reset");
        tick();
        Reset_n = 1'b1;
        idle("post_rst", 1'b0);
        send_frame("f1001", 4'b1001, 1'b1, 1'b0);
        idle("ack1001", 1'b1);

        for (int n = 0; n < 60; n++) begin
            send_frame("rnd", 4'($urandom_range(0, 15)), ($urandom_range(0, 4) != 0),
                       1'($urandom_range(0, 1)));
            for (int g = $urandom_range(0, 2); g > 0; g--)
                idle("rnd_idle", 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
